core_result_checker: RTL and testbench
======================================

# core_result_checker

Synthesizable run-monitor and result checker on the core's debug memory port. It observes the fetch stream and pipeline status to detect program halt and accumulate performance counters. After halt it walks data memory through the con_addr/con_out port and compares each word against an expected-value ROM. It produces pass/total counts, per-word fail pulses and a sticky done flag, so on-board regression runs need no simulator.

## Interface
Parameters:
- HALT_CYCLES, 50: consecutive cycles with unchanged if_inst that declare halt (≥2).
- ADDR_W, 10: word-address width of the con port and expected ROM.

Ports:
- CLK  in  1  system clock, rising edge.
- nrst  in  1  reset; asynchronous, active-low.
- if_inst  in  32  instruction currently in IF.
- if_stall  in  1  IF stall this cycle.
- flush  in  1  OR of ISR_PC_flush, ISR_pipe_flush, branch_flush.
- st_valid  in  1  EXE holds a store with nonzero byte-write mask.
- st_addr  in  ADDR_W  word address of that store (ALUout[ADDR_W+1:2]).
- con_addr  out  ADDR_W  data-memory read address.
- con_out  in  32  data-memory read data, 1-cycle latency.
- exp_addr  out  ADDR_W  expected-ROM address (always equals con_addr).
- exp_data  in  32  expected-ROM data, 1-cycle latency.
- cycle_count  out  32  net run cycles (halt window excluded).
- stall_count, flush_count, nop_count  out  32 each.
- max_addr  out  ADDR_W  highest stored word address.
- pass_count, total_count  out  ADDR_W+1.
- fail_valid  out  1  one-cycle pulse on mismatch; fail_addr  out  ADDR_W  its address.
- done  out  1  sticky, results final.
- all_pass  out  1  done && pass_count==total_count.

## Operation
- Reset: every output and internal register 0; state RUN; last_inst=0, match_cnt=0.
- Halt detect (RUN only): if if_inst==last_inst, match_cnt+1; otherwise last_inst<=if_inst, match_cnt<=0. At the edge where match_cnt reaches HALT_CYCLES-1 with a match, the block goes to SCAN. No counter updates on that edge.
- Counters (RUN only, all saturate at 32'hFFFFFFFF):
  - cycle_count +1 per cycle.
  - stall_count +1 when if_stall.
  - flush_count +1 when flush.
  - nop_count +1 when if_inst[15:0]==16'h0001 or if_inst==32'h00000013.
- On the RUN→SCAN edge, cycle_count <= cycle_count − (HALT_CYCLES−1), floored at 0.
- max_addr: in RUN, if st_valid && st_addr>max_addr then update. st_valid is ignored outside RUN.
- FSM RUN→SCAN→DRAIN→DONE:
  - SCAN issues one address per cycle from 0 to max_addr inclusive.
  - After max_addr is issued, the FSM goes to DRAIN for one cycle to compare the last word.
  - Then DONE, which holds until reset. No address wrap: when max_addr is all-ones, the scan stops after it.
- Compare stage: a 1-cycle-delayed valid and address follow each issued address.
  - On each valid: total_count+1. If con_out==exp_data then pass_count+1; otherwise fail_valid=1 and fail_addr=that address.
- No stores during the run: max_addr=0, scan covers address 0 only, total_count=1.
- Reset asserted mid-scan: everything clears immediately to reset values and the FSM restarts in RUN.
- Counters stay frozen in SCAN/DRAIN/DONE.

## Timing
- Halt latency: SCAN is entered HALT_CYCLES−1 edges after the first repeated fetch, so the first address (0) is driven in the following cycle.
- con_addr/exp_addr are registered and change only on clock edges. They equal 0 in RUN and hold max_addr in DRAIN/DONE.
- Address a is issued at cycle t, compared at t+1, and counted in pass/total_count from t+2.
- Total scan length: max_addr+1 SCAN cycles plus 1 DRAIN cycle. done rises on the edge after DRAIN.
- fail_valid lasts exactly one cycle per mismatch; back-to-back mismatches give consecutive pulses.

## Test plan
- Halt detect, HALT_CYCLES=50: 200 distinct instructions, then hold if_inst=32'h0000006F. Required: SCAN entered after 49 repeated cycles; cycle_count=201 (200 distinct + 50 repeats − 49); no counter increments afterwards.
- Counters: pulse if_stall 7 times, flush 3 times, and feed 4×16'h0001 and 2×32'h00000013 before halt. Required: stall_count=7, flush_count=3, nop_count=6.
- Max tracking: stores to 5, 12, 3, then store to 20 during SCAN. Required: max_addr=12; scan covers 0..12; total_count=13.
- Compare: memory equals ROM except words 4 and 9 (word 4 gets 32'hDEADBEEF). Required: fail_valid pulses with fail_addr=4 then 9; pass_count=11; all_pass=0; done=1.
- Boundary cases:
  - No stores and a matching word 0: total_count=1, pass_count=1, all_pass=1.
  - max_addr=1023: total_count=1024 with no wrap; con_addr stays 1023.
- Async reset: drop nrst mid-scan (address 6) between clock edges. Required: all outputs 0 immediately; after release, the FSM is in RUN and counting restarts.

Source files
------------

// File: rtl/core_result_checker.sv
// Run monitor and result checker for the core's debug memory port.
// Watches the fetch stream for a halt loop while collecting run counters, then
// walks data memory 0..max_addr and compares each word against an expected ROM.
module core_result_checker #(
    parameter int unsigned HALT_CYCLES = 50,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              CLK,
    input  logic              nrst,
    input  logic [31:0]       if_inst,
    input  logic              if_stall,
    input  logic              flush,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    output logic [ADDR_W-1:0] con_addr,
    input  logic [31:0]       con_out,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [31:0]       exp_data,
    output logic [31:0]       cycle_count,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count,
    output logic [31:0]       nop_count,
    output logic [ADDR_W-1:0] max_addr,
    output logic [ADDR_W:0]   pass_count,
    output logic [ADDR_W:0]   total_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              done,
    output logic              all_pass
);

    typedef enum logic [1:0] {StRun, StScan, StDrain, StDone} state_e;

    // Repeated fetches that are part of the halt window, removed from cycle_count.
    localparam logic [31:0]       HaltLast = 32'(HALT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    state_e            state_q, state_d;
    logic [31:0]       last_inst_q, last_inst_d;
    logic [31:0]       match_cnt_q, match_cnt_d;
    logic [31:0]       cycle_q, cycle_d, stall_q, stall_d, flush_q, flush_d, nop_q, nop_d;
    logic [ADDR_W-1:0] max_q, max_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [ADDR_W:0]   pass_q, pass_d, total_q, total_d;
    logic              fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic              done_q, done_d;

    logic inst_match, halt, is_nop, word_ok;

    assign inst_match = (if_inst == last_inst_q);
    assign halt       = (state_q == StRun) && inst_match && (match_cnt_q == HaltLast);
    assign is_nop     = (if_inst[15:0] == 16'h0001) || (if_inst == 32'h0000_0013);
    assign word_ok    = (con_out == exp_data);

    // Scan sequencer: issue one address per SCAN cycle, stop at max_addr without wrapping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            StRun:   if (halt) state_d = StScan;
            StScan:  begin
                if (addr_q == max_q) state_d = StDrain;
                else                 addr_d  = addr_q + AddrOne;
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StRun;
        endcase
    end

    // Halt detection, run counters and store-address high-water mark (RUN only).
    always_comb begin
        last_inst_d = last_inst_q;
        match_cnt_d = match_cnt_q;
        cycle_d     = cycle_q;
        stall_d     = stall_q;
        flush_d     = flush_q;
        nop_d       = nop_q;
        max_d       = max_q;
        if (state_q == StRun) begin
            if (inst_match) begin
                match_cnt_d = match_cnt_q + 32'd1;
            end else begin
                last_inst_d = if_inst;
                match_cnt_d = '0;
            end
            if (st_valid && (st_addr > max_q)) max_d = st_addr;
            if (halt) begin
                // Halt edge: drop the idle-loop window instead of counting this cycle.
                cycle_d = (cycle_q > HaltLast) ? cycle_q - HaltLast : '0;
            end else begin
                cycle_d = sat_inc(cycle_q, 1'b1);
                stall_d = sat_inc(stall_q, if_stall);
                flush_d = sat_inc(flush_q, flush);
                nop_d   = sat_inc(nop_q, is_nop);
            end
        end
    end

    // Compare stage: memory and ROM data arrive one cycle after the address.
    always_comb begin
        cmp_valid_d  = (state_q == StScan);
        cmp_addr_d   = addr_q;
        pass_d       = pass_q;
        total_d      = total_q;
        fail_valid_d = 1'b0;
        fail_addr_d  = fail_addr_q;
        done_d       = done_q | (state_q == StDrain);
        if (cmp_valid_q) begin
            total_d = total_q + CntOne;
            if (word_ok) begin
                pass_d = pass_q + CntOne;
            end else begin
                fail_valid_d = 1'b1;
                fail_addr_d  = cmp_addr_q;
            end
        end
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StRun;
            last_inst_q  <= '0;
            match_cnt_q  <= '0;
            cycle_q      <= '0;
            stall_q      <= '0;
            flush_q      <= '0;
            nop_q        <= '0;
            max_q        <= '0;
            addr_q       <= '0;
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= '0;
            pass_q       <= '0;
            total_q      <= '0;
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_inst_q  <= last_inst_d;
            match_cnt_q  <= match_cnt_d;
            cycle_q      <= cycle_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
            nop_q        <= nop_d;
            max_q        <= max_d;
            addr_q       <= addr_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_addr_q   <= cmp_addr_d;
            pass_q       <= pass_d;
            total_q      <= total_d;
            fail_valid_q <= fail_valid_d;
            fail_addr_q  <= fail_addr_d;
            done_q       <= done_d;
        end
    end

    assign con_addr    = addr_q;
    assign exp_addr    = addr_q;
    assign cycle_count = cycle_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;
    assign nop_count   = nop_q;
    assign max_addr    = max_q;
    assign pass_count  = pass_q;
    assign total_count = total_q;
    assign fail_valid  = fail_valid_q;
    assign fail_addr   = fail_addr_q;
    assign done        = done_q;
    assign all_pass    = done_q && (pass_q == total_q);

endmodule

// File: tb/tb_core_result_checker.sv
// Bench for core_result_checker: table of run/scan scenarios plus a mid-scan reset sequence.
// Memory and ROM are modelled with 1-cycle read latency; expected fail addresses are queued
// when the memory image is built and popped as fail pulses appear.
module tb_core_result_checker;

    localparam int unsigned HC = 50;
    localparam int unsigned AW = 10;

    logic          CLK = 1'b0;
    logic          nrst;
    logic [31:0]   if_inst;
    logic          if_stall, flush, st_valid;
    logic [AW-1:0] st_addr, con_addr, exp_addr, max_addr, fail_addr;
    logic [31:0]   con_out, exp_data;
    logic [31:0]   cycle_count, stall_count, flush_count, nop_count;
    logic [AW:0]   pass_count, total_count;
    logic          fail_valid, done, all_pass;

    core_result_checker #(.HALT_CYCLES(HC), .ADDR_W(AW)) dut (
        .CLK(CLK), .nrst(nrst), .if_inst(if_inst), .if_stall(if_stall), .flush(flush),
        .st_valid(st_valid), .st_addr(st_addr), .con_addr(con_addr), .con_out(con_out),
        .exp_addr(exp_addr), .exp_data(exp_data), .cycle_count(cycle_count),
        .stall_count(stall_count), .flush_count(flush_count), .nop_count(nop_count),
        .max_addr(max_addr), .pass_count(pass_count), .total_count(total_count),
        .fail_valid(fail_valid), .fail_addr(fail_addr), .done(done), .all_pass(all_pass)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [1024];
    logic [31:0] rom [1024];

    always @(posedge CLK) begin
        con_out  <= mem[con_addr];
        exp_data <= rom[exp_addr];
    end

    typedef struct {
        int          n_st;
        logic [AW-1:0] st0, st1, st2;
        int          n_fail;
        logic [AW-1:0] fa0, fa1;
        logic        scan_store;
        logic [AW-1:0] exp_max;
        int          exp_total;
        int          exp_pass;
        logic        exp_all;
    } vec_t;

    vec_t vecs [4];

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW-1:0] sb_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return (|cycle_count) | (|stall_count) | (|flush_count) | (|nop_count) | (|max_addr) |
               (|pass_count) | (|total_count) | fail_valid | (|fail_addr) | done | all_pass |
               (|con_addr) | (|exp_addr);
    endfunction

    // Scoreboard: every fail pulse must match the next queued address.
    always @(negedge CLK) begin
        if (nrst === 1'b1 && fail_valid === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_fail_pulse: got addr %0d expected no pulse", fail_addr);
            end else begin
                if (fail_addr !== sb_q[0]) begin
                    n_fail++;
                    $display("FAIL fail_addr: got %0d expected %0d", fail_addr, sb_q[0]);
                end
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_in(input logic [31:0] inst, input logic stl, input logic fl,
                          input logic sv, input logic [AW-1:0] sa);
        if_inst  = inst;
        if_stall = stl;
        flush    = fl;
        st_valid = sv;
        st_addr  = sa;
    endtask

    task automatic init_mem(input vec_t v);
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 32'hA500_0000 | 32'(i);
            mem[i] = rom[i];
        end
        sb_q.delete();
        if (v.n_fail > 0) begin
            mem[v.fa0] = 32'hDEAD_BEEF;
            sb_q.push_back(v.fa0);
        end
        if (v.n_fail > 1) begin
            mem[v.fa1] = ~rom[v.fa1];
            sb_q.push_back(v.fa1);
        end
    endtask

    // Reset, run a 200-instruction program, then hold a jump-to-self until SCAN.
    // Returns at the negedge of the first SCAN cycle.
    task automatic run_to_scan(input vec_t v);
        logic [31:0]   inst;
        logic          stl, fl, sv;
        logic [AW-1:0] sa;
        nrst = 1'b0;
        set_in(32'h0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge CLK);
        @(negedge CLK);
        check("reset_outputs_zero", {63'd0, any_out()}, 64'd0);
        nrst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            inst = {16'(i + 1), 16'h2033};
            if (i >= 10 && i <= 13) inst = {16'(i + 1), 16'h0001};
            if (i == 20 || i == 30) inst = 32'h0000_0013;
            stl = (i == 3 || i == 40 || i == 41 || i == 42 || i == 100 || i == 150 || i == 199);
            fl  = (i == 5 || i == 77 || i == 180);
            sv  = 1'b0;
            sa  = '1;
            if (i == 50 && v.n_st > 0) begin sv = 1'b1; sa = v.st0; end
            if (i == 60 && v.n_st > 1) begin sv = 1'b1; sa = v.st1; end
            if (i == 70 && v.n_st > 2) begin sv = 1'b1; sa = v.st2; end
            set_in(inst, stl, fl, sv, sa);
            step();
        end
        check("cycles_after_program", 64'(cycle_count), 64'd200);
        set_in(32'h0000_006F, 1'b0, 1'b0, 1'b0, '0);
        repeat (HC) step();
        check("cycles_before_halt", 64'(cycle_count), 64'd250);
        step();
        check("cycle_count_at_halt", 64'(cycle_count), 64'd201);
        check("stall_count", 64'(stall_count), 64'd7);
        check("flush_count", 64'(flush_count), 64'd3);
        check("nop_count", 64'(nop_count), 64'd6);
        check("max_addr_run", 64'(max_addr), 64'(v.exp_max));
        check("first_scan_addr", 64'(con_addr), 64'd0);
    endtask

    task automatic scan_and_check(input vec_t v);
        int bad = 0;
        for (int k = 0; k <= int'(v.exp_max); k++) begin
            if (con_addr !== AW'(k) || exp_addr !== AW'(k)) bad++;
            if (k == 2) check("total_at_scan_cycle2", 64'(total_count), 64'd1);
            if (v.scan_store && k < 3) set_in(32'h0000_006F, 1'b1, 1'b1, 1'b1, AW'(20));
            else                       set_in(32'h0000_006F, 1'b0, 1'b0, 1'b0, '0);
            step();
        end
        check("scan_addr_seq", 64'(bad), 64'd0);
        check("drain_addr", 64'(con_addr), 64'(v.exp_max));
        check("done_before_drain_edge", {63'd0, done}, 64'd0);
        step();
        check("done", {63'd0, done}, 64'd1);
        check("total_count", 64'(total_count), 64'(v.exp_total));
        check("pass_count", 64'(pass_count), 64'(v.exp_pass));
        check("all_pass", {63'd0, all_pass}, {63'd0, v.exp_all});
        check("con_addr_hold", 64'(con_addr), 64'(v.exp_max));
        // Frozen after DONE, even with stall/flush/nop activity and stores.
        set_in(32'h0000_0013, 1'b1, 1'b1, 1'b1, '1);
        repeat (4) step();
        check("frozen_cycle", 64'(cycle_count), 64'd201);
        check("frozen_stall_flush_nop",
              {stall_count[15:0], flush_count[15:0], nop_count[15:0], 16'd0},
              {16'd7, 16'd3, 16'd6, 16'd0});
        check("frozen_max_addr", 64'(max_addr), 64'(v.exp_max));
        check("done_sticky", {63'd0, done}, 64'd1);
        check("frozen_total", 64'(total_count), 64'(v.exp_total));
        check("fail_scoreboard_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        vecs[0] = '{n_st: 3, st0: 5, st1: 12, st2: 3, n_fail: 2, fa0: 4, fa1: 9, scan_store: 1'b1,
                    exp_max: 12, exp_total: 13, exp_pass: 11, exp_all: 1'b0};
        vecs[1] = '{n_st: 0, st0: 0, st1: 0, st2: 0, n_fail: 0, fa0: 0, fa1: 0, scan_store: 1'b0,
                    exp_max: 0, exp_total: 1, exp_pass: 1, exp_all: 1'b1};
        vecs[2] = '{n_st: 1, st0: 1023, st1: 0, st2: 0, n_fail: 0, fa0: 0, fa1: 0,
                    scan_store: 1'b0, exp_max: 1023, exp_total: 1024, exp_pass: 1024,
                    exp_all: 1'b1};
        vecs[3] = '{n_st: 2, st0: 7, st1: 2, st2: 0, n_fail: 1, fa0: 7, fa1: 0, scan_store: 1'b0,
                    exp_max: 7, exp_total: 8, exp_pass: 7, exp_all: 1'b0};

        nrst = 1'b0;
        set_in(32'h0, 1'b0, 1'b0, 1'b0, '0);

        for (int s = 0; s < 4; s++) begin
            init_mem(vecs[s]);
            run_to_scan(vecs[s]);
            scan_and_check(vecs[s]);
        end

        // Asynchronous reset in the middle of a scan.
        vecs[0].n_fail = 0;
        vecs[0].scan_store = 1'b0;
        init_mem(vecs[0]);
        run_to_scan(vecs[0]);
        repeat (6) step();
        check("midscan_addr", 64'(con_addr), 64'd6);
        check("midscan_total", 64'(total_count), 64'd5);
        #2 nrst = 1'b0;
        #1 check("async_reset_outputs_zero", {63'd0, any_out()}, 64'd0);
        @(negedge CLK);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(32'h0100_0000 + 32'(i), 1'b0, 1'b0, 1'b0, '0);
            step();
        end
        check("restart_cycle_count", 64'(cycle_count), 64'd3);
        check("restart_con_addr", 64'(con_addr), 64'd0);
        check("restart_done", {63'd0, done}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
